// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC, single-outstanding memory reads, DEPTH-entry prefetch queue, redirect flush.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a returning word straight to decode when the queue is empty.
module fetch_queue_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_mem_ready_i,
  input  logic [DATA_W-1:0] instr_mem_data_i,
  output logic [ADDR_W-1:0] instr_mem_addr_o,
  output logic              instr_mem_rd_o,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  input  logic              stall_i,
  output logic              instr_valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_addr_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {S_FETCH, S_DROP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] drop_addr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];

  logic              xfer;
  logic              empty;
  logic              bypass_hit;
  logic              q_push;
  logic              q_pop;
  logic [ADDR_W-1:0] redirect_pc;

  assign xfer        = instr_mem_rd_o & instr_mem_ready_i;
  assign empty       = (count_q == '0);
  assign redirect_pc = redirect_addr_i & ~ADDR_W'(3);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_hit = (state_q == S_FETCH) & empty & xfer & ~redirect_i;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed word that decode takes immediately never occupies a queue slot.
  assign q_push = (state_q == S_FETCH) & xfer & ~redirect_i & ~(bypass_hit & ~stall_i);
  assign q_pop  = ~empty & ~stall_i & ~redirect_i & ~rst_i;

  always_comb begin
    count_d = count_q;
    if (q_push && !q_pop) count_d = count_q + CNT_W'(1);
    else if (!q_push && q_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (redirect_i && instr_mem_rd_o && !instr_mem_ready_i) state_d = S_DROP;
      S_DROP:  if (instr_mem_ready_i) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    instr_mem_rd_o   = ~rst_i & ((state_q == S_DROP) | (count_q < CNT_W'(DEPTH)));
    instr_mem_addr_o = (state_q == S_DROP) ? drop_addr_q : pc_q;
    instr_valid_o    = (~empty | bypass_hit) & ~redirect_i & ~rst_i;
    instr_o          = bypass_hit ? instr_mem_data_i : data_mem_q[rd_ptr_q];
    instr_addr_o     = bypass_hit ? pc_q : addr_mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (redirect_i) begin
      pc_q     <= redirect_pc;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (q_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (q_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if ((state_q == S_FETCH) && xfer) pc_q <= pc_q + ADDR_W'(4);
    end
  end

  // The abandoned read keeps its address on the bus until memory completes it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == S_FETCH && state_d == S_DROP) drop_addr_q <= pc_q;
  end

  always_ff @(posedge clk_i) begin
    if (q_push) begin
      data_mem_q[wr_ptr_q] <= instr_mem_data_i;
      addr_mem_q[wr_ptr_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: a queue-based reference model predicts bus and delivery behaviour.
module tb_fetch_queue_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_mem_ready_i = 1'b0;
  logic [31:0] instr_mem_data_i = '0;
  logic [31:0] instr_mem_addr_o;
  logic        instr_mem_rd_o;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic        stall_i = 1'b0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_addr_o;

  fetch_queue_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_mem_ready_i(instr_mem_ready_i), .instr_mem_data_i(instr_mem_data_i),
    .instr_mem_addr_o(instr_mem_addr_o), .instr_mem_rd_o(instr_mem_rd_o),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i), .stall_i(stall_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_addr_o(instr_addr_o)
  );

  always #5 clk = ~clk;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state: {addr, data} pairs in arrival order.
  logic [63:0] mq[$];
  logic [63:0] exp_q[$];
  logic [31:0] m_pc = 32'h0;
  bit          m_drop = 1'b0;
  logic [31:0] m_drop_addr = 32'h0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, predict outputs, then advance the model across the coming edge.
  task automatic step(input bit r, input bit rdy, input bit st, input bit rd, input logic [31:0] ra);
    bit          e_rd, e_valid, xfer, byp, popq;
    logic [31:0] e_addr, d;
    @(negedge clk);
    rst_i = r; instr_mem_ready_i = rdy; stall_i = st; redirect_i = rd; redirect_addr_i = ra;
    instr_mem_data_i = memfn(instr_mem_addr_o);
    #1;
    if (r) begin
      chk("rd_in_reset", {63'd0, instr_mem_rd_o}, 64'd0);
      chk("valid_in_reset", {63'd0, instr_valid_o}, 64'd0);
      m_pc = 32'h0; mq.delete(); m_drop = 1'b0;
      return;
    end
    e_rd   = m_drop ? 1'b1 : (mq.size() < DEPTH);
    e_addr = m_drop ? m_drop_addr : m_pc;
    xfer   = e_rd && rdy;
    d      = memfn(e_addr);
    byp    = BYP && !m_drop && mq.size() == 0 && xfer && !rd;
    e_valid = (mq.size() != 0 || byp) && !rd;
    chk("mem_rd", {63'd0, instr_mem_rd_o}, {63'd0, e_rd});
    if (e_rd) chk("mem_addr", {32'd0, instr_mem_addr_o}, {32'd0, e_addr});
    chk("instr_valid", {63'd0, instr_valid_o}, {63'd0, e_valid});
    if (e_valid && !st) exp_q.push_back(byp ? {m_pc, d} : mq[0]);
    if (rd) begin
      if (!m_drop && e_rd && !rdy) begin m_drop = 1'b1; m_drop_addr = m_pc; end
      else if (m_drop && rdy) m_drop = 1'b0;
      mq.delete();
      m_pc = {ra[31:2], 2'b00};
    end else if (m_drop) begin
      if (rdy) m_drop = 1'b0;
    end else begin
      popq = mq.size() != 0 && !st;
      if (popq) void'(mq.pop_front());
      if (xfer) begin
        if (!(byp && !st)) mq.push_back({m_pc, d});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Monitor: every word decode accepts must match the next predicted delivery.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_i && instr_valid_o && !stall_i && !redirect_i) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_delivery at %0t: got addr %h, nothing expected", $time, instr_addr_o);
        end else begin
          e = exp_q.pop_front();
          chk("deliver_addr", {32'd0, instr_addr_o}, {32'd0, e[63:32]});
          chk("deliver_data", {32'd0, instr_o}, {32'd0, e[31:0]});
        end
      end
    end
  end

  initial begin
    int mode, p_rdy, p_st;
    repeat (2) step(1, 0, 0, 0, 0);
    // Straight-line run, then fill with stall held and drain.
    repeat (4) step(0, 1, 0, 0, 0);
    repeat (8) step(0, 1, 1, 0, 0);
    repeat (6) step(0, 1, 0, 0, 0);
    // Redirect while a read is pending, memory slow for three cycles.
    step(0, 0, 1, 1, 32'h103);
    repeat (2) step(0, 0, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0);
    // Redirect coincident with a transfer.
    step(0, 1, 0, 1, 32'h200);
    repeat (3) step(0, 1, 0, 0, 0);
    // Full queue, then pop together with redirect.
    repeat (6) step(0, 1, 1, 0, 0);
    step(0, 1, 0, 1, 32'h300);
    repeat (3) step(0, 1, 0, 0, 0);
    // Reset in the middle of a drop.
    step(0, 0, 0, 1, 32'h400);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 2400; i++) begin
      mode = (i / 300) % 3;
      p_rdy = (mode == 0) ? 90 : 50;
      p_st  = (mode == 0) ? 10 : (mode == 1) ? 50 : 90;
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < p_rdy),
           ($urandom_range(0, 99) < p_st),
           ($urandom_range(0, 99) < 5),
           $urandom);
    end
    @(negedge clk);
    #3;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
